// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the data-store bus.
//   A store to BASE_ADDR pushes wdata[7:0] into a small FIFO.
//   A load from BASE_ADDR+4 returns STATUS.
//   A store to BASE_ADDR+4 with wdata[2]=1 clears the sticky overflow flag.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   we     store strobe
//   re     load strobe (qualifies rdata)
//   addr   byte address
//   wdata  store data
//   rdata  combinational load data: STATUS = {25'b0, count, overflow, empty, full}
//   tx     registered serial line, idles high
//   busy   FSM not idle or FIFO non-empty
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [BW-1:0]   baud, baud_n;
  logic [2:0]      bitcnt, bitcnt_n;
  logic [7:0]      shift, shift_n;
  logic            tx_n;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [3:0]      count;
  logic            overflow;
  logic            empty, full;

  logic            pop;
  logic            push_req, push_ok, push_drop, ovf_clr;
  logic            baud_last;

  assign empty = (count == 4'd0);
  assign full  = (count == 4'(FIFO_DEPTH));
  assign busy  = (state != IDLE) || !empty;

  assign push_req  = we && (addr == BASE_ADDR);
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok   = push_req && (!full || pop);
  assign push_drop = push_req && full && !pop;
  assign ovf_clr   = we && (addr == BASE_ADDR + 32'd4) && wdata[2];

  // Only the low byte of a TXDATA store is meaningful.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  always_comb begin
    rdata = '0;
    if (re && (addr == BASE_ADDR + 32'd4))
      rdata = {25'b0, count, overflow, empty, full};
  end

  // FIFO storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      count <= count + 4'(push_ok) - 4'(pop);
      // A dropped push outranks a clear on the same edge.
      if (push_drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      baud   <= '0;
      bitcnt <= '0;
      shift  <= '0;
      tx     <= 1'b1;
    end else begin
      state  <= state_n;
      baud   <= baud_n;
      bitcnt <= bitcnt_n;
      shift  <= shift_n;
      tx     <= tx_n;
    end
  end

  always_comb begin
    state_n  = state;
    baud_n   = baud + BW'(1);
    bitcnt_n = bitcnt;
    shift_n  = shift;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (!empty) begin
          pop      = 1'b1;
          shift_n  = mem[rd_ptr];
          bitcnt_n = '0;
          state_n  = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_n  = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_n = '0;
          if (bitcnt == 3'd7) begin
            state_n = STOP;
          end else begin
            shift_n  = shift >> 1;
            bitcnt_n = bitcnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_n = '0;
          if (!empty) begin
            pop      = 1'b1;
            shift_n  = mem[rd_ptr];
            bitcnt_n = '0;
            state_n  = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        baud_n  = '0;
        state_n = IDLE;
      end
    endcase
  end

  // tx is computed from the next state so the registered line changes on the
  // same edge as the state it represents.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic        re;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .CLKS_PER_BIT(16),
    .FIFO_DEPTH(4),
    .BASE_ADDR(32'h0000_1000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .we(we),
    .re(re),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .tx(tx),
    .busy(busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Expected line level at cycle c (0..159) of an 8N1 frame, 16 clocks per bit.
  function automatic logic frame_lvl(input logic [7:0] b, input int unsigned c);
    int unsigned lvl;
    lvl = c / 16;
    if (lvl == 0) return 1'b0;
    if (lvl >= 9) return 1'b1;
    return b[lvl-1];
  endfunction

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] v);
    re = 1'b1; addr = a;
    #1;
    v = rdata;
    re = 1'b0; addr = '0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    load(32'h1004, v);
    n_cmp++; if (v !== 32'h2) begin n_bad++; $display("FAIL reset_status: got %h want 00000002", v); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL idle_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    load(32'h1004, v);
    n_cmp++; if (v !== 32'h2) begin n_bad++; $display("FAIL idle_status: got %h want 00000002", v); end
  endtask

  task automatic test_single_byte;
    logic [31:0] v;
    store(32'h1000, 32'hFFFF_FF55);
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL single_tx_before_start: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_rise: got %b want 1", busy); end
    load(32'h1004, v);
    n_cmp++; if (v !== 32'h8) begin n_bad++; $display("FAIL single_status_push: got %h want 00000008", v); end
    for (int unsigned c = 0; c < 160; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (tx !== frame_lvl(8'h55, c)) begin
        n_bad++; $display("FAIL single_bit c=%0d: got %b want %b", c, tx, frame_lvl(8'h55, c));
      end
    end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_last_stop: got %b want 1", busy); end
    @(posedge clk);
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL single_tx_after: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_fall: got %b want 0", busy); end
    load(32'h1004, v);
    n_cmp++; if (v !== 32'h2) begin n_bad++; $display("FAIL single_status_end: got %h want 00000002", v); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    logic [7:0]  b2b [3];
    b2b[0] = 8'h41; b2b[1] = 8'h42; b2b[2] = 8'h43;
    store(32'h1000, 32'h41);
    load(32'h1004, v);
    n_cmp++; if (v !== 32'h8) begin n_bad++; $display("FAIL b2b_status_1: got %h want 00000008", v); end
    // Second push coincides with the pop of the first byte: count stays 1.
    store(32'h1000, 32'h42);
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL b2b_start_c0: got %b want 0", tx); end
    load(32'h1004, v);
    n_cmp++; if (v !== 32'h8) begin n_bad++; $display("FAIL b2b_status_2: got %h want 00000008", v); end
    store(32'h1000, 32'h43);
    load(32'h1004, v);
    n_cmp++; if (v !== 32'h10) begin n_bad++; $display("FAIL b2b_status_3: got %h want 00000010", v); end
    for (int unsigned c = 2; c < 480; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (tx !== frame_lvl(b2b[c/160], c % 160)) begin
        n_bad++; $display("FAIL b2b_bit c=%0d: got %b want %b", c, tx, frame_lvl(b2b[c/160], c % 160));
      end
      if (c == 200) begin
        load(32'h1004, v);
        n_cmp++; if (v !== 32'h8) begin n_bad++; $display("FAIL b2b_status_c200: got %h want 00000008", v); end
      end
      if (c == 400) begin
        load(32'h1004, v);
        n_cmp++; if (v !== 32'h2) begin n_bad++; $display("FAIL b2b_status_c400: got %h want 00000002", v); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_c400: got %b want 1", busy); end
      end
    end
    @(posedge clk);
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL b2b_tx_after: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_fall: got %b want 0", busy); end
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    for (int unsigned i = 0; i < 6; i++)
      store(32'h1000, 32'h60 + i + 1);
    load(32'h1004, v);
    n_cmp++; if (v !== 32'h25) begin n_bad++; $display("FAIL ovf_status_full: got %h want 00000025", v); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ovf_busy: got %b want 1", busy); end
    store(32'h1004, 32'h4);
    load(32'h1004, v);
    n_cmp++; if (v !== 32'h21) begin n_bad++; $display("FAIL ovf_status_clear: got %h want 00000021", v); end
  endtask

  // Runs right after test_overflow: first frame began on the edge after the
  // first push, so its STOP ends 155 edges after the clear store.
  task automatic test_push_pop_full;
    logic [31:0] v;
    repeat (154) @(posedge clk);
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL pp_stop_level: got %b want 1", tx); end
    store(32'h1000, 32'h77);
    load(32'h1004, v);
    n_cmp++; if (v !== 32'h21) begin n_bad++; $display("FAIL pp_status: got %h want 00000021", v); end
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL pp_next_start: got %b want 0", tx); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] v;
    #1;
    reset = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL rst_mid_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    load(32'h1004, v);
    n_cmp++; if (v !== 32'h2) begin n_bad++; $display("FAIL rst_mid_status: got %h want 00000002", v); end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL rst_after_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_after_busy: got %b want 0", busy); end
    load(32'h1004, v);
    n_cmp++; if (v !== 32'h2) begin n_bad++; $display("FAIL rst_after_status: got %h want 00000002", v); end
  endtask

  task automatic test_decode;
    logic [31:0] v;
    store(32'h1008, 32'h55);
    store(32'h0000_0000, 32'h55);
    load(32'h1004, v);
    n_cmp++; if (v !== 32'h2) begin n_bad++; $display("FAIL dec_status: got %h want 00000002", v); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dec_busy: got %b want 0", busy); end
    for (int unsigned c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL dec_tx c=%0d: got %b want 1", c, tx); end
    end
    load(32'h1008, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL dec_load_1008: got %h want 00000000", v); end
    load(32'h1000, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL dec_load_txdata: got %h want 00000000", v); end
    re = 1'b0; addr = 32'h1004;
    #1;
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL dec_no_re: got %h want 00000000", rdata); end
    addr = '0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_push_pop_full();
    test_reset_mid_frame();
    test_decode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
